tail_light_seq: RTL

//  Parametrised sequential tail-light driver for an N-digit multiplexed 7-seg display.

---
 rtl/tail_light_pkg.sv | 13 +
 rtl/step_prescaler.sv | 29 ++
 rtl/tail_light_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/tail_light_pkg.sv
// Shared types and constants for the tail-light sequencer.
package tail_light_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } mode_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler: counts 0..STEP_CYCLES-1 while enabled and pulses tick on the wrap cycle.
module step_prescaler #(
    parameter int STEP_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tail_light_seq.sv
// Tail-light sweep/flash driver for a multiplexed 7-seg display (active-low anodes and segments).
// Optional brake input when TAIL_LIGHT_BRAKE_EN is defined.
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int         NUM_DIGITS  = 4,
    parameter int         STEP_CYCLES = 25_000_000,
    parameter logic [7:0] SEG_PATTERN = 8'hC6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  left,
    input  logic                  right,
    input  logic                  hazard,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            sseg,
    output logic [1:0]            mode_o,
    output logic                  tick_o
`ifdef TAIL_LIGHT_BRAKE_EN
    ,
    input  logic                  brake
`endif
);

    localparam int SW   = $clog2(NUM_DIGITS + 1);
    localparam int HALF = NUM_DIGITS / 2;
    localparam logic [SW-1:0] LAST_STEP = SW'(NUM_DIGITS);

    mode_e                 mode, mode_req;
    logic [SW-1:0]         step, step_nxt;
    logic                  change, pre_en, pre_clr, pre_tick;
    logic [NUM_DIGITS-1:0] lit;
    int                    step_i;

    assign step_i = int'(step);
    assign mode_o = mode;

    // Request priority: hazard (or both turn signals) wins over a single turn.
    always_comb begin
        mode_req = IDLE;
        if (hazard || (left && right)) mode_req = HAZARD;
        else if (left)                 mode_req = LEFT;
        else if (right)                mode_req = RIGHT;
    end

    assign change  = (mode_req != mode);
    assign pre_en  = en && (mode != IDLE);
    assign pre_clr = change || (mode == IDLE);
    assign tick_o  = pre_tick && !change;

    step_prescaler #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (pre_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mode <= IDLE;
        else       mode <= mode_req;
    end

    always_comb begin
        step_nxt = step;
        if (change) begin
            step_nxt = '0;
        end else if (tick_o) begin
            case (mode)
                LEFT, RIGHT: step_nxt = (step == LAST_STEP) ? '0 : step + 1'b1;
                HAZARD:      step_nxt = (step == '0) ? SW'(1) : '0;
                default:     step_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) step <= '0;
        else       step <= step_nxt;
    end

    // Pattern decode: lit[i]=1 means digit i is on.
    always_comb begin
        lit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            case (mode)
                LEFT:    lit[i] = (step_i < NUM_DIGITS) && (i <= step_i);
                RIGHT:   lit[i] = (step_i < NUM_DIGITS) && (i >= NUM_DIGITS - 1 - step_i);
                HAZARD:  lit[i] = (step == '0);
                default: lit[i] = 1'b0;
            endcase
`ifdef TAIL_LIGHT_BRAKE_EN
            // Brake forces the non-sweeping half on; hazard flashing is left alone.
            if (brake && ((mode == IDLE) ||
                          (mode == LEFT  && i >= HALF) ||
                          (mode == RIGHT && i <  HALF)))
                lit[i] = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an   <= '1;
            sseg <= SEG_BLANK;
        end else begin
            an   <= ~lit;
            sseg <= (|lit) ? SEG_PATTERN : SEG_BLANK;
        end
    end

endmodule
